gate_bist_checker: RTL and testbench



---
 rtl/gate_pkg.sv | 28 ++
 rtl/settle_counter.sv | 36 +++
 rtl/gate_bist_checker.sv | 167 ++++++++++++++++
 tb/tb_gate_bist_checker.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared states, truth tables and vector constants for the gate BIST block
package gate_pkg;

  // Sequencer states; IDLE=0 .. DONE=4
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Expected y indexed by {a,b}
  localparam logic [3:0] TT_AND = 4'b1000;
  localparam logic [3:0] TT_OR  = 4'b1110;
  localparam logic [3:0] TT_XOR = 4'b0110;

  // A 2-input gate has four input vectors
  localparam int         VEC_COUNT = 4;
  localparam logic [1:0] VEC_LAST  = 2'(VEC_COUNT - 1);
  localparam logic [2:0] ERR_MAX   = 3'(VEC_COUNT);

  // Error counter increment that cannot pass the number of vectors
  function automatic logic [2:0] err_sat_inc(input logic [2:0] v);
    return (v >= ERR_MAX) ? ERR_MAX : v + 3'd1;
  endfunction

endpackage

// File: rtl/settle_counter.sv
// rtl/settle_counter.sv - loadable down-counter with zero flag for the settle wait
module settle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority; decrement stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_bist_checker.sv
// rtl/gate_bist_checker.sv - drives a 2-input gate through all vectors and checks it; GATE_BIST_FAILCAP_EN adds first-failure capture
module gate_bist_checker
  import gate_pkg::*;
#(
  parameter logic [3:0] TRUTH  = TT_AND,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count
`ifdef GATE_BIST_FAILCAP_EN
  ,
  output logic [1:0] fail_vec,
  output logic       fail_valid
`endif
);

  // Counter starts at SETTLE-1 so the SETTLE state lasts exactly SETTLE cycles
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [1:0] ab_q, ab_d;
  logic [2:0] err_q, err_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic       run_start;
  logic       mismatch;
`ifdef GATE_BIST_FAILCAP_EN
  logic [1:0] fvec_q, fvec_d;
  logic       fvalid_q, fvalid_d;
`endif

  settle_counter #(
    .W(4)
  ) u_settle (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(SETTLE_LOAD),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  // start is honoured only when no run is in progress
  assign run_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign mismatch  = (y != TRUTH[ab_q]);

  // Next-state and datapath; status outputs lag the state by one edge
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    ab_d     = ab_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    busy_d   = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    done_d   = 1'b0;
    pass_d   = 1'b0;
`ifdef GATE_BIST_FAILCAP_EN
    fvec_d   = fvec_q;
    fvalid_d = fvalid_q;
`endif

    if (run_start) begin
      state_d = ST_APPLY;
      vec_d   = '0;
      err_d   = '0;
`ifdef GATE_BIST_FAILCAP_EN
      fvec_d   = '0;
      fvalid_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_APPLY: begin
          ab_d     = vec_q;
          cnt_load = 1'b1;
          state_d  = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            state_d = ST_CHECK;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_d = err_sat_inc(err_q);
`ifdef GATE_BIST_FAILCAP_EN
            if (!fvalid_q) begin
              fvec_d   = ab_q;
              fvalid_d = 1'b1;
            end
`endif
          end
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
          end else begin
            vec_d   = vec_q + 2'd1;
            state_d = ST_APPLY;
          end
        end
        ST_DONE: begin
          done_d = 1'b1;
          pass_d = (err_q == 3'd0);
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and result registers; reset aborts any run without a result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      ab_q     <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
`ifdef GATE_BIST_FAILCAP_EN
      fvec_q   <= '0;
      fvalid_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      ab_q     <= ab_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
`ifdef GATE_BIST_FAILCAP_EN
      fvec_q   <= fvec_d;
      fvalid_q <= fvalid_d;
`endif
    end
  end

  assign a         = ab_q[1];
  assign b         = ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
`ifdef GATE_BIST_FAILCAP_EN
  assign fail_vec   = fvec_q;
  assign fail_valid = fvalid_q;
`endif

endmodule

// File: tb/tb_gate_bist_checker.sv
// tb/tb_gate_bist_checker.sv - directed self-checking bench for gate_bist_checker
module tb_gate_bist_checker;
  import gate_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] gate_sel;

  logic       a, b, y, busy, done, pass;
  logic [2:0] err_count;
  logic       ax, bx, yx, busyx, donex, passx;
  logic [2:0] errx;
`ifdef GATE_BIST_FAILCAP_EN
  logic [1:0] fail_vec, fvecx;
  logic       fail_valid, fvalidx;
`endif

  int n_checks = 0;
  int n_err    = 0;

  // Gate under test: AND, or output stuck at 0
  assign y  = (gate_sel == 2'd1) ? 1'b0 : (a & b);
  // Second checker expects XOR but is wired to an AND gate
  assign yx = ax & bx;

  gate_bist_checker #(.TRUTH(TT_AND), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef GATE_BIST_FAILCAP_EN
    , .fail_vec(fail_vec), .fail_valid(fail_valid)
`endif
  );

  gate_bist_checker #(.TRUTH(TT_XOR), .SETTLE(2)) dutx (
    .clk(clk), .rst(rst), .start(start), .a(ax), .b(bx), .y(yx),
    .busy(busyx), .done(donex), .pass(passx), .err_count(errx)
`ifdef GATE_BIST_FAILCAP_EN
    , .fail_vec(fvecx), .fail_valid(fvalidx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a"}, {3'b0, a}, 4'd0);
    chk({tag, "_b"}, {3'b0, b}, 4'd0);
    chk({tag, "_busy"}, {3'b0, busy}, 4'd0);
    chk({tag, "_done"}, {3'b0, done}, 4'd0);
    chk({tag, "_pass"}, {3'b0, pass}, 4'd0);
    chk({tag, "_err"}, {1'b0, err_count}, 4'd0);
`ifdef GATE_BIST_FAILCAP_EN
    chk({tag, "_fvec"}, {2'b0, fail_vec}, 4'd0);
    chk({tag, "_fvalid"}, {3'b0, fail_valid}, 4'd0);
`endif
  endtask

  // start sampled at edge 0; vectors appear after edges 1,5,9,13; done at edge 17
  task automatic run_check(input string tag, input logic pulses,
                           input logic [2:0] exp_err, input logic exp_pass);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk({tag, "_e0_done"}, {3'b0, done}, 4'd0);
    chk({tag, "_e0_err"}, {1'b0, err_count}, 4'd0);
    tick(1);
    chk({tag, "_e1_busy"}, {3'b0, busy}, 4'd1);
    chk({tag, "_e1_ab"}, {2'b0, a, b}, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      tick(3);
      if (pulses && (k < 3)) start = 1'b1;
      tick(1);
      start = 1'b0;
      chk({tag, "_ab_step"}, {2'b0, a, b}, 4'(k));
    end
    tick(3);
    chk({tag, "_e16_done"}, {3'b0, done}, 4'd0);
    chk({tag, "_e16_busy"}, {3'b0, busy}, 4'd1);
    tick(1);
    chk({tag, "_e17_done"}, {3'b0, done}, 4'd1);
    chk({tag, "_e17_busy"}, {3'b0, busy}, 4'd0);
    chk({tag, "_e17_err"}, {1'b0, err_count}, {1'b0, exp_err});
    chk({tag, "_e17_pass"}, {3'b0, pass}, {3'b0, exp_pass});
  endtask

  // Directed sequence
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    gate_sel = 2'd0;
    tick(2);
    chk_reset("rst");
    rst = 1'b0;
    tick(2);
    chk("idle_busy", {3'b0, busy}, 4'd0);
    chk("idle_done", {3'b0, done}, 4'd0);

    // Correct AND gate
    run_check("and", 1'b0, 3'd0, 1'b1);
    chk("xor_done", {3'b0, donex}, 4'd1);
    chk("xor_err", {1'b0, errx}, 4'd3);
    chk("xor_pass", {3'b0, passx}, 4'd0);
`ifdef GATE_BIST_FAILCAP_EN
    chk("xor_fvec", {2'b0, fvecx}, 4'b0001);
    chk("xor_fvalid", {3'b0, fvalidx}, 4'd1);
    chk("and_fvalid", {3'b0, fail_valid}, 4'd0);
`endif
    tick(3);
    chk("hold_done", {3'b0, done}, 4'd1);
    chk("hold_pass", {3'b0, pass}, 4'd1);

    // Output stuck at 0: only vector 11 mismatches
    gate_sel = 2'd1;
    run_check("zero", 1'b0, 3'd1, 1'b0);
`ifdef GATE_BIST_FAILCAP_EN
    chk("zero_fvec", {2'b0, fail_vec}, 4'b0011);
    chk("zero_fvalid", {3'b0, fail_valid}, 4'd1);
`endif

    // Restart from DONE with a good gate and mid-run start pulses
    gate_sel = 2'd0;
    run_check("rerun", 1'b1, 3'd0, 1'b1);
`ifdef GATE_BIST_FAILCAP_EN
    chk("rerun_fvalid", {3'b0, fail_valid}, 4'd0);
`endif

    // Reset during a run at edge 8
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(7);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_reset("midrst");
    tick(3);
    chk("midrst_idle_busy", {3'b0, busy}, 4'd0);
    chk("midrst_idle_done", {3'b0, done}, 4'd0);
    run_check("postrst", 1'b0, 3'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
